// File: rtl/uart_led_ctrl_pkg.sv
// Shared types and constants for the UART-driven 7-segment command controller.
package uart_led_ctrl_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned ERRCNT_W = 8;

    // Frame parser states: one step per received byte after SYNC
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } state_e;

    localparam logic [BYTE_W-1:0] CMD_WRITE_DIGIT = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_BLANK_MASK  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_CLEAR_ALL   = 8'h03;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 3'd0,
        ERR_PARITY   = 3'd1,
        ERR_CSUM     = 3'd2,
        ERR_BAD_CMD  = 3'd3,
        ERR_BAD_ADDR = 3'd4,
        ERR_TIMEOUT  = 3'd5
    } err_code_e;

    // True for opcodes the controller knows how to execute
    function automatic logic cmd_known(input logic [BYTE_W-1:0] c);
        return (c == CMD_WRITE_DIGIT) || (c == CMD_BLANK_MASK) || (c == CMD_CLEAR_ALL);
    endfunction

endpackage

// File: rtl/uart_led_timeout.sv
// Inter-byte timeout counter: runs while enabled, pulses expire_c on the LIMIT-th idle cycle.
module uart_led_timeout #(
    parameter int unsigned LIMIT = 50000
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // A clear in the same cycle suppresses expiry, so an arriving byte always wins
    assign expire_c = en && !clr && (cnt_q == LAST);

    // Count idle cycles; hold at the last value until cleared
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA/CSUM frames from the UART byte stream and drives the 7-segment register file.
module uart_led_cmd_ctrl
    import uart_led_ctrl_pkg::*;
#(
    parameter int unsigned     CLK_FREQ   = 50,
    parameter int unsigned     NUM_DIGITS = 4,
    parameter int unsigned     TIMEOUT_US = 1000,
    parameter logic [7:0]      SYNC_BYTE  = 8'hA5
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [7:0]                s_tdata,
    input  logic                      s_tuser,
    input  logic                      s_tvalid,
    output logic [4*NUM_DIGITS-1:0]   digit_val,
    output logic [NUM_DIGITS-1:0]     digit_dp,
    output logic [NUM_DIGITS-1:0]     digit_blank,
    output logic                      frame_ok,
    output logic                      frame_err,
    output logic [2:0]                err_code,
    output logic [7:0]                err_cnt
);

    localparam int unsigned TO_LIMIT = CLK_FREQ * TIMEOUT_US;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] cmd_q, addr_q, data_q;
    logic              cap_cmd, cap_addr, cap_data;
    logic              exec, abort;
    err_code_e         abort_code;
    logic              to_clr, to_en, expire_c;
    logic [IDX_W-1:0]  widx;

    assign to_en  = (state_q != IDLE);
    assign to_clr = (state_q == IDLE) || s_tvalid;
    assign widx   = IDX_W'(addr_q);

    uart_led_timeout #(
        .LIMIT    (TO_LIMIT)
    ) u_timeout (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clr      (to_clr),
        .en       (to_en),
        .expire_c (expire_c)
    );

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, capture strobes and frame verdict
    always_comb begin
        state_d    = state_q;
        cap_cmd    = 1'b0;
        cap_addr   = 1'b0;
        cap_data   = 1'b0;
        exec       = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        if (state_q == IDLE) begin
            if (s_tvalid && (s_tdata == SYNC_BYTE)) begin
                state_d = CMD;
            end
        end else if (s_tvalid) begin
            if (s_tuser) begin
                abort      = 1'b1;
                abort_code = ERR_PARITY;
            end else begin
                case (state_q)
                    CMD: begin
                        cap_cmd = 1'b1;
                        state_d = ADDR;
                    end
                    ADDR: begin
                        cap_addr = 1'b1;
                        state_d  = DATA;
                    end
                    DATA: begin
                        cap_data = 1'b1;
                        state_d  = CSUM;
                    end
                    CSUM: begin
                        state_d = IDLE;
                        if (s_tdata != (cmd_q ^ addr_q ^ data_q)) begin
                            abort      = 1'b1;
                            abort_code = ERR_CSUM;
                        end else if (!cmd_known(cmd_q)) begin
                            abort      = 1'b1;
                            abort_code = ERR_BAD_CMD;
                        end else if ((cmd_q == CMD_WRITE_DIGIT) &&
                                     (addr_q >= BYTE_W'(NUM_DIGITS))) begin
                            abort      = 1'b1;
                            abort_code = ERR_BAD_ADDR;
                        end else begin
                            exec = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (expire_c) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Frame field capture
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (cap_cmd)  cmd_q  <= s_tdata;
            if (cap_addr) addr_q <= s_tdata;
            if (cap_data) data_q <= s_tdata;
        end
    end

    // Status pulses and sticky error reporting
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            err_cnt   <= '0;
        end else begin
            frame_ok  <= exec;
            frame_err <= abort;
            if (abort) begin
                err_code <= abort_code;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

    // Display register file, updated only by a fully validated frame
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            digit_val   <= '0;
            digit_dp    <= '0;
            digit_blank <= '1;
        end else if (exec) begin
            case (cmd_q)
                CMD_WRITE_DIGIT: begin
                    digit_val[{widx, 2'b00} +: 4] <= data_q[3:0];
                    digit_dp[widx]                <= data_q[7];
                    digit_blank[widx]             <= 1'b0;
                end
                CMD_BLANK_MASK: begin
                    digit_blank <= NUM_DIGITS'(data_q);
                end
                CMD_CLEAR_ALL: begin
                    digit_val   <= '0;
                    digit_dp    <= '0;
                    digit_blank <= '1;
                end
                default: ;
            endcase
        end
    end

endmodule
